// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The optional ovf signal exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout, zero);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  io_bus
);
    localparam int S     = WIDTH / DIGIT;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(S - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic             r_zero;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             r_ovf;
`endif

    logic [DIGIT:0]   w_sub;
    logic [WIDTH-1:0] w_merged;
    logic             w_last;

    // One slice of the difference; the top bit of w_sub is the outgoing borrow.
    always_comb begin
        w_sub    = {1'b0, r_a[int'(r_cnt) * DIGIT +: DIGIT]}
                 - {1'b0, r_b[int'(r_cnt) * DIGIT +: DIGIT]}
                 - {{DIGIT{1'b0}}, r_borrow};
        w_merged = r_shadow;
        w_merged[int'(r_cnt) * DIGIT +: DIGIT] = w_sub[DIGIT-1:0];
    end

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_a      <= io_bus.a;
                        r_b      <= io_bus.b;
                        r_borrow <= io_bus.bin;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_shadow <= w_merged;
                    r_borrow <= w_sub[DIGIT];
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                    // Visible results change only here, so partial sums never leak out.
                    if (w_last) begin
                        r_diff  <= w_merged;
                        r_bout  <= w_sub[DIGIT];
                        r_zero  <= (w_merged == '0);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_merged[WIDTH-1] != r_a[WIDTH-1]);
`endif
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy = (r_state != ST_IDLE);
    assign io_bus.done = r_done;
    assign io_bus.diff = r_diff;
    assign io_bus.bout = r_bout;
    assign io_bus.zero = r_zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign io_bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: four instances (W1/D1, W8/D1, W8/D4, W8/D2).
// Stimulus pushes expected results; per-instance monitors pop and compare on done.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(1)) if0 ();
    serial_subtractor_if #(.WIDTH(8)) if1 ();
    serial_subtractor_if #(.WIDTH(8)) if2 ();
    serial_subtractor_if #(.WIDTH(8)) if3 ();

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .io_bus(if0));
    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .io_bus(if1));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst_n(rst_n), .io_bus(if2));
    serial_subtractor #(.WIDTH(8), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .io_bus(if3));

    logic ovf0, ovf1, ovf2, ovf3;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf0 = if0.ovf;
    assign ovf1 = if1.ovf;
    assign ovf2 = if2.ovf;
    assign ovf3 = if3.ovf;
`else
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
    assign ovf3 = 1'b0;
`endif

    typedef struct packed {
        int         id;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
        logic       chk_ovf;
        int         acc;
        int         lat;
    } exp_t;

    exp_t q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lat_of(input int id);
        case (id)
            0:       return 1;
            1:       return 8;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic busy_of(input int id);
        case (id)
            0:       return if0.busy;
            1:       return if1.busy;
            2:       return if2.busy;
            default: return if3.busy;
        endcase
    endfunction

    task automatic drive(input int id, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
        case (id)
            0: begin if0.start = st; if0.a = a[0]; if0.b = b[0]; if0.bin = bin; end
            1: begin if1.start = st; if1.a = a;    if1.b = b;    if1.bin = bin; end
            2: begin if2.start = st; if2.a = a;    if2.b = b;    if2.bin = bin; end
            default: begin if3.start = st; if3.a = a; if3.b = b; if3.bin = bin; end
        endcase
    endtask

    // Issue one operation; the accepting edge is the posedge after this negedge.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic push, input logic [7:0] ed, input logic eb, input logic ez,
                         input logic eo, input logic co);
        exp_t e;
        @(negedge clk);
        drive(id, 1'b1, a, b, bin);
        @(posedge clk);
        #1;
        if (push) begin
            e = '{id: id, diff: ed, bout: eb, zero: ez, ovf: eo, chk_ovf: co, acc: cyc, lat: lat_of(id)};
            q.push_back(e);
        end
        drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        @(negedge clk);
        while (busy_of(id) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_of(id)) begin
            nchk++;
            nerr++;
            $display("FAIL wait_idle dut%0d still busy after 40 cycles", id);
        end
    endtask

    task automatic check_done(input int id, input logic [7:0] diff, input logic bout,
                              input logic zero, input logic ovf);
        exp_t e;
        if (q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_done dut%0d actual=done required=no_done", id);
        end else begin
            e = q.pop_front();
            cmp($sformatf("done_dut%0d", id), id, e.id);
            cmp($sformatf("diff_dut%0d", id), {24'h0, diff}, {24'h0, e.diff});
            cmp($sformatf("bout_dut%0d", id), {31'h0, bout}, {31'h0, e.bout});
            cmp($sformatf("zero_dut%0d", id), {31'h0, zero}, {31'h0, e.zero});
            cmp($sformatf("latency_dut%0d", id), cyc - e.acc, e.lat);
            if (e.chk_ovf) cmp($sformatf("ovf_dut%0d", id), {31'h0, ovf}, {31'h0, e.ovf});
        end
    endtask

    always @(negedge clk) if (rst_n && if0.done) check_done(0, {7'h0, if0.diff}, if0.bout, if0.zero, ovf0);
    always @(negedge clk) if (rst_n && if1.done) check_done(1, if1.diff, if1.bout, if1.zero, ovf1);
    always @(negedge clk) if (rst_n && if2.done) check_done(2, if2.diff, if2.bout, if2.zero, ovf2);
    always @(negedge clk) if (rst_n && if3.done) check_done(3, if3.diff, if3.bout, if3.zero, ovf3);

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_busy", {28'h0, if3.busy, if2.busy, if1.busy, if0.busy}, 32'h0);
        cmp("reset_done", {28'h0, if3.done, if2.done, if1.done, if0.done}, 32'h0);
        cmp("reset_diff", {if3.diff, if2.diff, if1.diff, 7'h0, if0.diff}, 32'h0);
        cmp("reset_bout_zero", {24'h0, if3.bout, if2.bout, if1.bout, if0.bout,
                                if3.zero, if2.zero, if1.zero, if0.zero}, 32'h0);
        rst_n = 1'b1;

        // Half-subtractor truth table, one-cycle latency
        issue(0, 8'h0, 8'h0, 1'b0, 1'b1, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle(0);
        issue(0, 8'h0, 8'h1, 1'b0, 1'b1, 8'h1, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle(0);
        issue(0, 8'h1, 8'h0, 1'b0, 1'b1, 8'h1, 1'b0, 1'b0, 1'b0, 1'b0); wait_idle(0);
        issue(0, 8'h1, 8'h1, 1'b0, 1'b1, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle(0);

        // Bit-serial 0x5A - 0x3C, busy for nine cycles, result held afterwards
        issue(1, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_cnt = 0;
        @(negedge clk);
        while (if1.busy && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clk);
        end
        cmp("busy_cycles_dut1", busy_cnt, 9);
        repeat (3) @(negedge clk);
        cmp("hold_diff_dut1", {24'h0, if1.diff}, 32'h1E);

        // Wrap-around 0 - 0 - 1
        issue(1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle(1);

        // Nibble-serial underflow and zero result with borrow in
        issue(2, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle(2);
        issue(2, 8'h37, 8'h36, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle(2);

        // start pulses while busy are ignored
        issue(3, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(3, 1'b1, 8'hFF, 8'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_idle(3);
        repeat (6) @(negedge clk);
        cmp("ignored_start_busy_dut3", {31'h0, if3.busy}, 32'h0);

        // Reset in the middle of an operation: no done for the aborted work
        issue(1, 8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cmp("midreset_busy", {31'h0, if1.busy}, 32'h0);
        cmp("midreset_done", {31'h0, if1.done}, 32'h0);
        cmp("midreset_diff", {24'h0, if1.diff}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 8'hAA, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0); wait_idle(1);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        issue(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1); wait_idle(1);
        issue(1, 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1); wait_idle(1);
        issue(1, 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1); wait_idle(1);
`endif

        repeat (4) @(negedge clk);
        cmp("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-bit subtractor. Computes A - B - Bin one DIGIT-wide slice per clock, LSB first, with the borrow carried between cycles in a register. Replaces combinational half/full subtractor chains wherever area matters more than latency. Uses a start/busy/done handshake and holds the registered result until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. Elaboration-time error otherwise.

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      synchronous reset, active-low
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; sampled on the accepting edge
b       input   WIDTH  subtrahend; sampled on the accepting edge
bin     input   1      borrow in; sampled on the accepting edge
busy    output  1      high in RUN and DONE
done    output  1      one-cycle pulse; result valid
diff    output  WIDTH  a - b - bin, modulo 2^WIDTH
bout    output  1      borrow out; 1 iff a < b + bin (unsigned)
zero    output  1      diff == 0

Behaviour:
- Reset: clk and rst_n form the single clock domain. rst_n is synchronous and active-low.
  - When rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, diff=0, bout=0, zero=0.
  - Internal operand registers, borrow register and slice counter also clear.
- States: IDLE, RUN, DONE. S = WIDTH/DIGIT.
- IDLE:
  - start=1 at edge k: latch a, b and bin; borrow register <= bin; counter <= 0; state becomes RUN.
  - start=0: stay in IDLE.
- RUN: on each edge, process slice i = counter.
  - {borrow', d_i} = a_slice - b_slice - borrow (DIGIT+1-bit arithmetic).
  - Write d_i into diff-shadow bits [i*DIGIT +: DIGIT].
  - Increment the counter.
  - The edge that processes slice S-1 is edge k+S. On that edge: diff <= shadow with the final slice merged; bout <= final borrow; zero <= (merged diff == 0); done <= 1; state becomes DONE.
- DONE: lasts one cycle. At edge k+S+1: done <= 0, state becomes IDLE.
  - The earliest next accepting edge is k+S+2.
- Timing summary:
  - busy rises after edge k and falls after edge k+S+1.
  - done is high for exactly the cycle between edges k+S and k+S+1.
- Output updates:
  - diff, bout and zero change only on the done edge or on reset.
  - They hold their values through IDLE until the next done.
  - They never show partial results.
- start while busy=1: ignored. No queuing, no effect on the operation in flight.
- Operand inputs outside the accepting edge: don't-care. The block works from its latched copies.
- Reset mid-operation (any state): the reset values above apply at that edge. The aborted operation produces no done.
- Wrap-around: underflow wraps modulo 2^WIDTH and sets bout=1.
  - Example: 0 - 0 - 1 = all ones, bout=1.
- WIDTH=1, DIGIT=1 with bin=0 reduces exactly to a half subtractor: diff = a^b, bout = ~a&b. Latency is 1 cycle to done.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset to 0.
  - Updated only on the done edge: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. two's-complement signed overflow of a - b - bin.
  - Held with diff.
- Undefined:
  - Port absent; no MSB capture logic.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=1, DIGIT=1, bin=0: apply a,b = 00, 01, 10, 11 -> (diff,bout) = (0,0), (1,1), (1,0), (0,0). done is high exactly 1 cycle after each accepting edge.
2. WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, zero=0. done in the cycle after edge k+8; busy high for 9 cycles.
3. WIDTH=8, DIGIT=4: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, done after edge k+2. Then a=0x37, b=0x36, bin=1 -> diff=0x00, bout=0, zero=1.
4. WIDTH=8, DIGIT=2: start 0x10 - 0x01. Pulse start with a=0xFF, b=0x00 at edges k+1 and k+2 -> the first operation is unaffected (diff=0x0F). Exactly one done pulse.
5. WIDTH=8, DIGIT=1: start 0xAA - 0x55, drive rst_n=0 at edge k+3 -> busy=0, done=0, diff=0x00 on that edge. No done follows. A new start at k+5 gives its correct result.
6. With SERIAL_SUBTRACTOR_OVF_EN, WIDTH=8: 0x80 - 0x01 -> diff=0x7F, ovf=1, bout=0. 0x7F - 0xFF -> diff=0x80, ovf=1, bout=1. 0x05 - 0x03 -> ovf=0.
